// File: rtl/spi_rom_responder.sv
// SPI mode-0 read-only responder: accepts READ (0x03) plus a 24-bit address and
// streams bytes from a 1-clk-latency ROM with a one-byte prefetch.
//
// state  | meaning
// IDLE   | cs low, outputs quiet, waiting for cs
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in the 24-bit address
// DATA   | streaming ROM bytes on miso, prefetching the next byte
// IGNORE | unsupported command, wait for cs to drop
module spi_rom_responder #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  state_t state, state_nxt;

  logic cs_s1, cs_s2;
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall;

  logic [4:0]        bit_cnt;
  logic [6:0]        cmd_sr;
  logic [ADDR_W-2:0] addr_sr;
  logic [6:0]        shift_sr;
  logic [7:0]        pf_byte;
  logic              rd_d;

  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] addr_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;

  // Complete command/address values including the bit arriving on this rise.
  assign cmd_byte  = {cmd_sr, mosi_s2};
  assign addr_next = {addr_sr, mosi_s2};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs_s2) state_nxt = CMD;
      end
      CMD: begin
        if (!cs_s2) begin
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 5'd7) begin
          state_nxt = (cmd_byte == CMD_READ) ? ADDR : IGNORE;
        end
      end
      ADDR: begin
        if (!cs_s2) begin
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 5'd23) begin
          state_nxt = DATA;
        end
      end
      DATA, IGNORE: begin
        if (!cs_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 5'd0;
      cmd_sr   <= 7'd0;
      addr_sr  <= '0;
      shift_sr <= 7'd0;
      pf_byte  <= 8'd0;
      rd_d     <= 1'b0;
      spi_miso <= 1'b0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      cmd_err  <= 1'b0;
    end else begin
      rom_rd  <= 1'b0;
      cmd_err <= 1'b0;
      rd_d    <= rom_rd;
      if (!cs_s2) begin
        // Abort: a read issued on the way out must not land in the prefetch slot.
        bit_cnt  <= 5'd0;
        cmd_sr   <= 7'd0;
        addr_sr  <= '0;
        shift_sr <= 7'd0;
        pf_byte  <= 8'd0;
        rd_d     <= 1'b0;
        spi_miso <= 1'b0;
      end else begin
        if (rd_d) pf_byte <= rom_data;
        case (state)
          IDLE: begin
            bit_cnt <= 5'd0;
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_byte[6:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                cmd_err <= (cmd_byte != CMD_READ);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr_sr <= addr_next[ADDR_W-2:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= 5'd0;
                rom_rd   <= 1'b1;
                rom_addr <= addr_next;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            // bit_cnt == 0 marks a byte boundary: load prefetch and fetch the next one.
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                shift_sr <= pf_byte[6:0];
                spi_miso <= pf_byte[7];
                rom_addr <= rom_addr + ADDR_W'(1);
                rom_rd   <= 1'b1;
                bit_cnt  <= 5'd1;
              end else begin
                shift_sr <= {shift_sr[5:0], 1'b0};
                spi_miso <= shift_sr[6];
                bit_cnt  <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              end
            end
          end
          IGNORE: begin
            spi_miso <= 1'b0;
          end
          default: begin
            bit_cnt <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed bench for spi_rom_responder: SPI mode-0 controller model and a
// 1-clk-latency ROM whose byte is addr[7:0] ^ 0xA5.
module tb_spi_rom_responder;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              spi_cs;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic              busy;
  logic              cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_cycles = 0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [31:0] rx_word;
  logic [7:0]  pre_miso;

  spi_rom_responder #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd === 1'b1) begin
      rd_log.push_back(rom_addr);
      rom_data <= rom_addr[7:0] ^ 8'hA5;
    end
    if (cmd_err === 1'b1) err_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One mode-0 bit: fall (drive mosi), sample miso just before the rise, leave sclk high.
  task automatic spi_bit(input logic b, output logic m);
    spi_sclk = 1'b0;
    spi_mosi = b;
    repeat (5) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx = {rx[6:0], m};
    end
  endtask

  task automatic spi_begin();
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // cs is released while sclk is still high, so no trailing fall reaches DATA.
  task automatic spi_end(input string tag);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    check_eq({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_miso_off"}, {31'd0, spi_miso}, 32'd0);
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input int nbits);
    logic [7:0] rx;
    logic m;
    rx_word  = '0;
    pre_miso = 8'h00;
    spi_begin();
    spi_byte(cmd, rx);          pre_miso |= rx;
    spi_byte(addr[23:16], rx);  pre_miso |= rx;
    spi_byte(addr[15:8], rx);   pre_miso |= rx;
    spi_byte(addr[7:0], rx);    pre_miso |= rx;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(1'b0, m);
      rx_word = {rx_word[30:0], m};
    end
  endtask

  task automatic basic_read(input string tag);
    rd_log.delete();
    err_cycles = 0;
    do_read(8'h03, 24'h000010, 24);
    check_eq({tag, "_hdr_miso"}, {24'd0, pre_miso}, 32'd0);
    check_eq({tag, "_bytes"}, rx_word, 32'h00B5B4B7);
    spi_end(tag);
    check_eq({tag, "_rd_count"}, rd_log.size(), 32'd4);
    check_eq({tag, "_rd0"}, {21'd0, rd_log[0]}, 32'h010);
    check_eq({tag, "_rd1"}, {21'd0, rd_log[1]}, 32'h011);
    check_eq({tag, "_rd2"}, {21'd0, rd_log[2]}, 32'h012);
    check_eq({tag, "_rd3"}, {21'd0, rd_log[3]}, 32'h013);
    check_eq({tag, "_no_err"}, err_cycles, 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] miso_or;

    reset    = 1'b0;
    spi_cs   = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rst_rd", {31'd0, rom_rd}, 32'd0);
    check_eq("rst_addr", {21'd0, rom_addr}, 32'd0);
    check_eq("rst_err", {31'd0, cmd_err}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    basic_read("read10");

    // Unsupported command followed by 24 more clocks.
    rd_log.delete();
    err_cycles = 0;
    miso_or = 8'h00;
    spi_begin();
    spi_byte(8'h0B, rx);
    miso_or |= rx;
    check_eq("bad_err_pulse", err_cycles, 32'd1);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx);
      miso_or |= rx;
    end
    check_eq("bad_busy_held", {31'd0, busy}, 32'd1);
    check_eq("bad_miso", {24'd0, miso_or}, 32'd0);
    spi_end("bad");
    check_eq("bad_err_once", err_cycles, 32'd1);
    check_eq("bad_no_rd", rd_log.size(), 32'd0);

    // Address wrap at the top of an 11-bit space.
    rd_log.delete();
    do_read(8'h03, 24'h0007FF, 16);
    check_eq("wrap_bytes", rx_word, 32'h00005AA5);
    spi_end("wrap");
    check_eq("wrap_rd_count", rd_log.size(), 32'd3);
    check_eq("wrap_rd0", {21'd0, rd_log[0]}, 32'h7FF);
    check_eq("wrap_rd1", {21'd0, rd_log[1]}, 32'h000);
    check_eq("wrap_rd2", {21'd0, rd_log[2]}, 32'h001);

    // Upper address bits discarded.
    rd_log.delete();
    do_read(8'h03, 24'hFF0805, 8);
    check_eq("trunc_byte", rx_word, 32'h000000A0);
    spi_end("trunc");
    check_eq("trunc_rd0", {21'd0, rd_log[0]}, 32'h005);

    // Early cs drop after 12 data bits, then an immediate fresh read.
    rd_log.delete();
    do_read(8'h03, 24'h000020, 12);
    check_eq("abort_bits", rx_word, 32'h00000858);
    spi_end("abort");
    repeat (20) @(negedge clk);
    check_eq("abort_rd_count", rd_log.size(), 32'd3);
    rd_log.delete();
    do_read(8'h03, 24'h000000, 8);
    check_eq("again_byte", rx_word, 32'h000000A5);
    spi_end("again");
    check_eq("again_rd_count", rd_log.size(), 32'd2);

    // Reset in the middle of DATA (4 bits of 0xB5 already out, miso currently 1).
    do_read(8'h03, 24'h000010, 4);
    check_eq("mid_bits", rx_word, 32'h0000000B);
    check_eq("mid_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("mid_rst_rd", {31'd0, rom_rd}, 32'd0);
    check_eq("mid_rst_addr", {21'd0, rom_addr}, 32'd0);
    check_eq("mid_rst_err", {31'd0, cmd_err}, 32'd0);
    spi_cs   = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    basic_read("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
